issue_dispatch: RTL and testbench

Single-issue, in-order dispatch controller between the instruction decoder and the four execution pipes (ALU, MUL, MEM, BRU). It holds one decoded micro-op, checks register hazards against a 32-entry busy scoreboard, and waits for the target pipe to be ready. It enforces the MIPS branch-delay-slot rule: after a branch, exactly one slot uop issues, then issue stops until the BRU resolves the branch. On a redirect it drops the wrong-path uop.

---
 rtl/issue_dispatch_pkg.sv | 20 ++
 rtl/issue_scoreboard.sv | 45 ++++
 rtl/issue_dispatch.sv | 174 +++++++++++++++++
 tb/tb_issue_dispatch.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_dispatch_pkg.sv
// Shared definitions for the issue/dispatch controller: pipe one-hot bit
// positions, register index width and the dispatch FSM encodings.
package issue_dispatch_pkg;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned NUM_PIPES = 4;

  // Bit positions inside the one-hot pipe vector {bru, mem, mul, alu}
  localparam int unsigned PIPE_ALU = 0;
  localparam int unsigned PIPE_MUL = 1;
  localparam int unsigned PIPE_MEM = 2;
  localparam int unsigned PIPE_BRU = 3;

  typedef enum logic [1:0] {
    DISP_NORMAL = 2'd0,
    DISP_SLOT   = 2'd1,
    DISP_WAIT   = 2'd2
  } disp_state_e;

endpackage

// File: rtl/issue_scoreboard.sv
// 32-entry register busy scoreboard: one set port driven by issue, WB_PORTS
// clear ports driven by writeback, three combinational hazard read ports.
// Register 0 is never set, so it always reads as not busy.
module issue_scoreboard
  import issue_dispatch_pkg::*;
#(
  parameter int unsigned WB_PORTS = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      i_set_en,
  input  logic [REG_W-1:0]          i_set_idx,
  input  logic [WB_PORTS-1:0]       i_clr_en,
  input  logic [REG_W*WB_PORTS-1:0] i_clr_idx,
  input  logic [REG_W-1:0]          i_rd0_idx,
  input  logic [REG_W-1:0]          i_rd1_idx,
  input  logic [REG_W-1:0]          i_rd2_idx,
  output logic                      o_rd0_busy,
  output logic                      o_rd1_busy,
  output logic                      o_rd2_busy
);

  logic [31:0] r_busy;

  // Busy bits: writeback clears first, then an issue set overrides (set wins)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= '0;
    end else begin
      for (int unsigned i = 0; i < WB_PORTS; i++) begin
        if (i_clr_en[i]) begin
          r_busy[i_clr_idx[REG_W*i +: REG_W]] <= 1'b0;
        end
      end
      if (i_set_en && (i_set_idx != '0)) begin
        r_busy[i_set_idx] <= 1'b1;
      end
    end
  end

  assign o_rd0_busy = r_busy[i_rd0_idx];
  assign o_rd1_busy = r_busy[i_rd1_idx];
  assign o_rd2_busy = r_busy[i_rd2_idx];

endmodule

// File: rtl/issue_dispatch.sv
// Single-issue in-order dispatch: one-entry hold register, scoreboard hazard
// check, per-pipe ready handshake and branch-delay-slot sequencing.
module issue_dispatch
  import issue_dispatch_pkg::*;
#(
  parameter int unsigned UOP_W    = 48,
  parameter int unsigned WB_PORTS = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_src0,
  input  logic [4:0]            in_src1,
  input  logic [4:0]            in_dst,
  input  logic [3:0]            in_pipe,
  input  logic                  in_branch,
  input  logic [UOP_W-1:0]      in_uop,
  output logic [3:0]            iss_valid,
  input  logic [3:0]            iss_ready,
  output logic [4:0]            iss_src0,
  output logic [4:0]            iss_src1,
  output logic [4:0]            iss_dst,
  output logic [UOP_W-1:0]      iss_uop,
  input  logic [WB_PORTS-1:0]   wb_valid,
  input  logic [5*WB_PORTS-1:0] wb_dst,
  input  logic                  bru_done,
  input  logic                  bru_redirect,
  output logic [31:0]           stall_cnt
);

  logic                 r_held_valid;
  logic [REG_W-1:0]     r_held_src0;
  logic [REG_W-1:0]     r_held_src1;
  logic [REG_W-1:0]     r_held_dst;
  logic [NUM_PIPES-1:0] r_held_pipe;
  logic                 r_held_branch;
  logic [UOP_W-1:0]     r_held_uop;

  disp_state_e          r_state;
  disp_state_e          w_state_nxt;
  logic                 r_resolved;
  logic                 r_redir;
  logic                 w_resolved_nxt;
  logic                 w_redir_nxt;
  logic                 w_drop;

  logic [31:0]          r_stall_cnt;

  logic                 w_haz_src0;
  logic                 w_haz_src1;
  logic                 w_haz_dst;
  logic                 w_hazard;
  logic                 w_fire;
  logic                 w_load;

  // An early redirect seen during the slot needs no local action: the slot's
  // successor is squashed upstream. The flag is kept for observability only.
  logic                 w_unused_redir;
  assign w_unused_redir = r_redir;

  issue_scoreboard #(
    .WB_PORTS (WB_PORTS)
  ) u_scoreboard (
    .clk        (clk),
    .resetn     (resetn),
    .i_set_en   (w_fire),
    .i_set_idx  (r_held_dst),
    .i_clr_en   (wb_valid),
    .i_clr_idx  (wb_dst),
    .i_rd0_idx  (r_held_src0),
    .i_rd1_idx  (r_held_src1),
    .i_rd2_idx  (r_held_dst),
    .o_rd0_busy (w_haz_src0),
    .o_rd1_busy (w_haz_src1),
    .o_rd2_busy (w_haz_dst)
  );

  assign w_hazard = w_haz_src0 | w_haz_src1 | w_haz_dst;
  assign w_fire   = r_held_valid & ~w_hazard & (|(r_held_pipe & iss_ready))
                  & (r_state != DISP_WAIT);
  assign in_ready = ~r_held_valid | w_fire;
  assign w_load   = in_valid & in_ready;

  assign iss_valid = w_fire ? r_held_pipe : '0;
  assign iss_src0  = r_held_src0;
  assign iss_src1  = r_held_src1;
  assign iss_dst   = r_held_dst;
  assign iss_uop   = r_held_uop;
  assign stall_cnt = r_stall_cnt;

  // Hold register; a new load takes priority so a uop arriving alongside a
  // redirect survives while the wrong-path uop already held is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_held_valid  <= 1'b0;
      r_held_src0   <= '0;
      r_held_src1   <= '0;
      r_held_dst    <= '0;
      r_held_pipe   <= '0;
      r_held_branch <= 1'b0;
      r_held_uop    <= '0;
    end else begin
      if (w_load) begin
        r_held_valid  <= 1'b1;
        r_held_src0   <= in_src0;
        r_held_src1   <= in_src1;
        r_held_dst    <= in_dst;
        r_held_pipe   <= in_pipe;
        r_held_branch <= in_branch;
        r_held_uop    <= in_uop;
      end else if (w_fire || w_drop) begin
        r_held_valid  <= 1'b0;
      end
    end
  end

  // Dispatch FSM state and early-resolve latches
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= DISP_NORMAL;
      r_resolved <= 1'b0;
      r_redir    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_resolved <= w_resolved_nxt;
      r_redir    <= w_redir_nxt;
    end
  end

  // Next-state: branch opens the slot, slot fire closes it, WAIT ends on resolve
  always_comb begin
    w_state_nxt    = r_state;
    w_resolved_nxt = r_resolved;
    w_redir_nxt    = r_redir;
    w_drop         = 1'b0;
    unique case (r_state)
      DISP_NORMAL: begin
        if (w_fire && r_held_branch) begin
          w_state_nxt = DISP_SLOT;
        end
      end
      DISP_SLOT: begin
        if (w_fire) begin
          w_state_nxt    = (r_resolved || bru_done) ? DISP_NORMAL : DISP_WAIT;
          w_resolved_nxt = 1'b0;
          w_redir_nxt    = 1'b0;
        end else if (bru_done) begin
          w_resolved_nxt = 1'b1;
          w_redir_nxt    = bru_redirect;
        end
      end
      DISP_WAIT: begin
        if (bru_done) begin
          w_state_nxt = DISP_NORMAL;
          w_drop      = bru_redirect;
        end
      end
      default: begin
        w_state_nxt = DISP_NORMAL;
      end
    endcase
  end

  // Stall counter: held uop present but not issued this cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (r_held_valid && !w_fire) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_issue_dispatch.sv
// Testbench for issue_dispatch: a directed vector table, hand-written
// branch/backpressure/reset sequences and a randomized run against a
// transaction-level reference model.
module tb_issue_dispatch;
  import issue_dispatch_pkg::*;

  localparam int unsigned UOP_W = 48;
  localparam int unsigned WBP   = 4;
  localparam logic [3:0] P_ALU = 4'(1 << PIPE_ALU);
  localparam logic [3:0] P_MUL = 4'(1 << PIPE_MUL);
  localparam logic [3:0] P_MEM = 4'(1 << PIPE_MEM);
  localparam logic [3:0] P_BRU = 4'(1 << PIPE_BRU);

  logic             clk;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_src0, in_src1, in_dst;
  logic [3:0]       in_pipe;
  logic             in_branch;
  logic [UOP_W-1:0] in_uop;
  logic [3:0]       iss_valid;
  logic [3:0]       iss_ready;
  logic [4:0]       iss_src0, iss_src1, iss_dst;
  logic [UOP_W-1:0] iss_uop;
  logic [WBP-1:0]   wb_valid;
  logic [5*WBP-1:0] wb_dst;
  logic             bru_done;
  logic             bru_redirect;
  logic [31:0]      stall_cnt;

  int unsigned n_vec;
  int unsigned n_err;

  issue_dispatch #(
    .UOP_W    (UOP_W),
    .WB_PORTS (WBP)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_src0      (in_src0),
    .in_src1      (in_src1),
    .in_dst       (in_dst),
    .in_pipe      (in_pipe),
    .in_branch    (in_branch),
    .in_uop       (in_uop),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_src0     (iss_src0),
    .iss_src1     (iss_src1),
    .iss_dst      (iss_dst),
    .iss_uop      (iss_uop),
    .wb_valid     (wb_valid),
    .wb_dst       (wb_dst),
    .bru_done     (bru_done),
    .bru_redirect (bru_redirect),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_src0      = '0;
    in_src1      = '0;
    in_dst       = '0;
    in_pipe      = '0;
    in_branch    = 1'b0;
    in_uop       = '0;
    iss_ready    = 4'hF;
    wb_valid     = '0;
    wb_dst       = '0;
    bru_done     = 1'b0;
    bru_redirect = 1'b0;
  endtask

  task automatic present(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] d,
                         input logic [3:0] pipe, input logic br);
    in_valid  = 1'b1;
    in_src0   = s0;
    in_src1   = s1;
    in_dst    = d;
    in_pipe   = pipe;
    in_branch = br;
    in_uop    = {16'($urandom), $urandom};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Directed per-cycle vectors; expected outputs are the values seen in the
  // cycle the inputs are presented (before the following edge).
  typedef struct {
    logic        v;
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic [4:0]  d;
    logic [3:0]  pipe;
    logic [3:0]  rdy;
    logic [3:0]  wbv;
    logic [19:0] wbd;
    logic [3:0]  exp_iss;
    logic        exp_rdy;
    logic [31:0] exp_stall;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                              input logic [4:0] d, input logic [3:0] pipe,
                              input logic [3:0] wbv, input logic [19:0] wbd,
                              input logic [3:0] ei, input logic er, input logic [31:0] es);
    vec_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.d = d; r.pipe = pipe; r.rdy = 4'hF;
    r.wbv = wbv; r.wbd = wbd; r.exp_iss = ei; r.exp_rdy = er; r.exp_stall = es;
    return r;
  endfunction

  // Reference model state (transaction level)
  logic             m_held;
  logic [4:0]       m_s0, m_s1, m_d;
  logic [3:0]       m_pipe;
  logic             m_br;
  logic [UOP_W-1:0] m_uop;
  logic [31:0]      m_busy;
  logic             m_br_out;   // branch issued and not yet resolved
  logic             m_slot;     // delay slot not yet consumed
  logic [31:0]      m_stall;
  logic             m_fire, m_haz, m_drop, m_load;

  initial begin
    n_vec  = 0;
    n_err  = 0;
    resetn = 1'b0;
    idle_inputs();
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_iss_valid", iss_valid, 0);
    chk("reset_stall", stall_cnt, 0);
    do_reset();

    // ---------------- table: back-to-back, RAW, r0, WAW ----------------
    tbl[0]  = mk(1, 0, 0, 1, P_ALU, 4'b0000, '0, 4'b0000, 1, 0);
    tbl[1]  = mk(1, 0, 0, 2, P_ALU, 4'b0000, '0, P_ALU,   1, 0);
    tbl[2]  = mk(1, 0, 0, 3, P_ALU, 4'b0000, '0, P_ALU,   1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,     4'b0000, '0, P_ALU,   1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,     4'b0111, {5'd0, 5'd3, 5'd2, 5'd1}, 4'b0000, 1, 0);
    tbl[5]  = mk(1, 1, 0, 5, P_ALU, 4'b0000, '0, 4'b0000, 1, 0);
    tbl[6]  = mk(1, 5, 0, 6, P_ALU, 4'b0000, '0, P_ALU,   1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0,     4'b0000, '0, 4'b0000, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0,     4'b0000, '0, 4'b0000, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0,     4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, 4'b0000, 0, 2);
    tbl[10] = mk(0, 0, 0, 0, 0,     4'b0000, '0, P_ALU,   1, 3);
    tbl[11] = mk(1, 0, 0, 0, P_MUL, 4'b0000, '0, 4'b0000, 1, 3);
    tbl[12] = mk(1, 0, 0, 0, P_ALU, 4'b0000, '0, P_MUL,   1, 3);
    tbl[13] = mk(0, 0, 0, 0, 0,     4'b0000, '0, P_ALU,   1, 3);
    tbl[14] = mk(1, 0, 0, 6, P_ALU, 4'b0000, '0, 4'b0000, 1, 3);
    tbl[15] = mk(0, 0, 0, 0, 0,     4'b1000, {5'd6, 5'd0, 5'd0, 5'd0}, 4'b0000, 0, 3);
    tbl[16] = mk(0, 0, 0, 0, 0,     4'b0000, '0, P_ALU,   1, 4);
    tbl[17] = mk(0, 0, 0, 0, 0,     4'b0000, '0, 4'b0000, 1, 4);

    for (int i = 0; i < 18; i++) begin
      idle_inputs();
      if (tbl[i].v) present(tbl[i].s0, tbl[i].s1, tbl[i].d, tbl[i].pipe, 1'b0);
      iss_ready = tbl[i].rdy;
      wb_valid  = tbl[i].wbv;
      wb_dst    = tbl[i].wbd;
      #1;
      chk($sformatf("tbl%0d_iss_valid", i), iss_valid, tbl[i].exp_iss);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_stall", i), stall_cnt, tbl[i].exp_stall);
      next_cycle();
    end

    // ---------------- branch, slot, wait, redirect drop ----------------
    do_reset();
    present(0, 0, 0, P_BRU, 1'b1);         // BEQ
    next_cycle();
    present(1, 2, 7, P_ALU, 1'b0);         // slot ADD
    #1 chk("br_fire", iss_valid, P_BRU);
    next_cycle();
    present(3, 0, 8, P_ALU, 1'b0);         // wrong-path SUB
    #1 chk("slot_fire", iss_valid, P_ALU);
    next_cycle();
    idle_inputs();
    #1 chk("wait_no_issue", iss_valid, 0);
    chk("wait_in_ready", in_ready, 0);
    next_cycle();
    bru_done = 1'b1;
    bru_redirect = 1'b1;
    #1 chk("wait_resolve_no_issue", iss_valid, 0);
    next_cycle();
    idle_inputs();
    #1 chk("redirect_dropped", in_ready, 1);
    chk("redirect_iss_valid", iss_valid, 0);
    chk("redirect_stall", stall_cnt, 2);
    present(0, 0, 9, P_ALU, 1'b0);
    next_cycle();
    idle_inputs();
    #1 chk("post_redirect_issue", iss_valid, P_ALU);

    // ---------------- early resolve during stalled slot ----------------
    do_reset();
    present(0, 0, 0, P_BRU, 1'b1);
    next_cycle();
    present(0, 0, 10, P_MEM, 1'b0);        // slot LW
    iss_ready = 4'b1011;
    #1 chk("early_br_fire", iss_valid, P_BRU);
    next_cycle();
    in_valid = 1'b0;
    bru_done = 1'b1;
    #1 chk("early_slot_blocked", iss_valid, 0);
    chk("early_slot_in_ready", in_ready, 0);
    next_cycle();
    bru_done = 1'b0;
    #1 chk("early_slot_blocked2", iss_valid, 0);
    next_cycle();
    iss_ready = 4'hF;
    present(0, 0, 11, P_ALU, 1'b0);
    #1 chk("early_slot_fire", iss_valid, P_MEM);
    next_cycle();
    idle_inputs();
    #1 chk("early_next_issue", iss_valid, P_ALU);

    // ---------------- backpressure then async reset ----------------
    do_reset();
    present(0, 0, 12, P_ALU, 1'b0);
    next_cycle();
    idle_inputs();
    #1 chk("bp_p_fire", iss_valid, P_ALU);
    next_cycle();
    present(0, 0, 13, P_ALU, 1'b0);
    iss_ready = 4'h0;
    next_cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("bp_no_issue%0d", i), iss_valid, 0);
      next_cycle();
    end
    #1 chk("bp_stall", stall_cnt, 5);
    chk("bp_in_ready", in_ready, 0);
    resetn = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_stall", stall_cnt, 0);
    next_cycle();
    resetn = 1'b1;
    iss_ready = 4'hF;
    present(12, 0, 14, P_ALU, 1'b0);       // would hazard on r12 if busy survived
    next_cycle();
    idle_inputs();
    #1 chk("rst_busy_cleared", iss_valid, P_ALU);
    next_cycle();

    // ---------------- randomized run against reference model ----------------
    do_reset();
    m_held = 0; m_s0 = 0; m_s1 = 0; m_d = 0; m_pipe = 0; m_br = 0; m_uop = '0;
    m_busy = '0; m_br_out = 0; m_slot = 0; m_stall = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_src0   = 5'($urandom_range(0, 7));
      in_src1   = 5'($urandom_range(0, 7));
      in_dst    = 5'($urandom_range(0, 7));
      in_pipe   = 4'(1 << $urandom_range(0, 3));
      in_branch = ($urandom_range(0, 9) < 2);
      in_uop    = {16'($urandom), $urandom};
      iss_ready = 4'($urandom) | 4'($urandom);
      for (int p = 0; p < WBP; p++) begin
        wb_valid[p]      = ($urandom_range(0, 9) < 3);
        wb_dst[5*p +: 5] = 5'($urandom_range(0, 7));
      end
      bru_done     = m_br_out && ($urandom_range(0, 4) == 0);
      bru_redirect = bru_done && ($urandom_range(0, 1) == 1);
      #1;
      m_haz  = m_busy[m_s0] | m_busy[m_s1] | m_busy[m_d];
      m_fire = m_held && !m_haz && ((m_pipe & iss_ready) != 0) && !(m_br_out && !m_slot);
      chk("rnd_iss_valid", iss_valid, m_fire ? m_pipe : 4'b0000);
      chk("rnd_in_ready", in_ready, !m_held || m_fire);
      chk("rnd_stall", stall_cnt, m_stall);
      if (m_held) begin
        chk("rnd_iss_src0", iss_src0, m_s0);
        chk("rnd_iss_src1", iss_src1, m_s1);
        chk("rnd_iss_dst", iss_dst, m_d);
        chk("rnd_iss_uop", iss_uop, m_uop);
      end
      @(posedge clk);
      if (m_held && !m_fire) m_stall = m_stall + 32'd1;
      for (int p = 0; p < WBP; p++) begin
        if (wb_valid[p]) m_busy[wb_dst[5*p +: 5]] = 1'b0;
      end
      if (m_fire && m_d != 0) m_busy[m_d] = 1'b1;
      m_drop = 1'b0;
      if (m_fire) begin
        if (m_slot) begin
          m_slot = 1'b0;
          if (bru_done) m_br_out = 1'b0;
        end else if (m_br) begin
          m_br_out = 1'b1;
          m_slot   = 1'b1;
        end
      end else if (bru_done && m_br_out) begin
        if (!m_slot) m_drop = bru_redirect;
        m_br_out = 1'b0;
      end
      m_load = in_valid && (!m_held || m_fire);
      if (m_load) begin
        m_held = 1'b1;
        m_s0 = in_src0; m_s1 = in_src1; m_d = in_dst;
        m_pipe = in_pipe; m_br = in_branch; m_uop = in_uop;
      end else if (m_fire || m_drop) begin
        m_held = 1'b0;
      end
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
